field_mult_arbiter: RTL and testbench
=====================================

Name: field_mult_arbiter

Overview:
- Shares one instance of the combinational 32-bit GF(2^32) multiplier `field_mult_32` among NREQ requesters.
- Round-robin arbitration; per-requester valid/ready handshake; result tagged with requester ID.
- Two-stage registered pipeline (operand register, product register) with output backpressure, so multiplier timing is isolated.
- Used by the authenticated-encryption core, where hash/tag logic and key-schedule logic both need field multiplications.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must satisfy 2^IDW >= NREQ.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  requester i has an operand pair pending.
- req_ready  output  NREQ  requester i's pair is accepted this cycle.
- req_a  input  32*NREQ  operand A of requester i, bits [32*i+31:32*i].
- req_b  input  32*NREQ  operand B of requester i, same packing.
- rsp_valid  output  1  rsp_data/rsp_id valid.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  IDW  index of the requester that issued the result.
- rsp_data  output  32  field product A*B.
- busy  output  1  any pipeline stage holds a valid entry.

Behaviour:
- Clock and reset: one clock `clk`; `rst` is synchronous and active-high.
- Reset values: v1=0, v2=0, rsp_valid=0, rsp_id=0, rsp_data=0, req_ready=0, busy=0, round-robin pointer ptr=0. Operand registers are cleared to 0.
- Stage 1 (S1): a_r, b_r, id1, v1.
- Stage 2 (S2): prod_r, id2, v2.
  - prod_r <= field_mult_32(a_r, b_r).
  - rsp_data=prod_r, rsp_id=id2, rsp_valid=v2.
- Advance rules (combinational):
  - adv2 = !v2 | rsp_ready
  - adv1 = !v1 | adv2
- Arbitration:
  - Among i with req_valid[i], grant the first index at or after ptr, scanning upward modulo NREQ.
  - req_ready[g] = adv1 & any(req_valid), and only for the granted g; all other bits are 0.
  - Grant is combinational and depends on req_valid, ptr and adv1 only. No combinational path from req_a/req_b to req_ready.
- Transfers:
  - On accept (req_valid[g] & req_ready[g]): a_r/b_r <= operands of g, id1 <= g, v1 <= 1, ptr <= (g+1) mod NREQ.
  - If adv1 and no request: v1 <= 0.
  - If adv2: v2 <= v1, and prod_r/id2 load from S1.
  - Stalled stages hold all contents.
- Latency: accept at cycle N -> rsp_valid at cycle N+2 when unstalled.
- Throughput: 1 result/cycle with rsp_ready held high.
- Backpressure:
  - rsp_ready=0 with v2=1 freezes S2.
  - S1 still fills if empty, then req_ready drops to 0.
  - Maximum in-flight count is 2. No entry is dropped or duplicated.
- ptr moves only on an accepted transfer. Requesters waiting under backpressure keep their priority order.
- Requester obligations: once req_valid is asserted, req_a/req_b must stay stable until accepted. The arbiter does not check this.
- Simultaneous response pop and new accept in one cycle are both allowed; the pipeline shifts as a unit.
- Reset mid-operation: all in-flight entries are discarded, rsp_valid=0 on the next cycle, ptr=0.
- busy = v1 | v2.
- Width rule: addition is XOR, multiply is the full field reduction performed by `field_mult_32`. The arbiter does no arithmetic of its own.

Test Plan:
1. Reset then single request:
   - Stimulus: req 2 with a=0x12345678, b=0x00000001.
   - Required: req_ready[2] high in the same cycle; rsp_valid 2 cycles later with rsp_data=0x12345678, rsp_id=2; ptr=3.
2. All four requesters valid from ptr=0 with rsp_ready=1:
   - Stimulus: operands a=0x2, b=0x2 on each.
   - Required: grants in order 0,1,2,3 on consecutive cycles; responses rsp_id 0,1,2,3, each rsp_data=0x4, back to back.
3. Backpressure:
   - Stimulus: hold rsp_ready=0 while req 1 and req 3 stream.
   - Required: exactly 2 accepts, then req_ready=0; rsp_data stable.
   - On release: ids 1 then 3 emerge in order, no loss.
4. Fairness:
   - Stimulus: req 0 continuously valid, req 1 pulses valid.
   - Required: req 1 granted within NREQ cycles of assertion; req 0 never granted twice in a row while req 1 waits.
5. Zero operand:
   - Stimulus: a=0xFFFFFFFF, b=0x00000000.
   - Required: rsp_data=0x00000000.
6. Mid-operation reset:
   - Stimulus: assert rst with v1=v2=1.
   - Required: next cycle rsp_valid=0, busy=0, req_ready=0; first request after reset is granted by ptr=0 ordering.

Source files
------------

// File: rtl/field_mult_arbiter.sv
// Round-robin arbiter sharing one GF(2^32) multiplier among NREQ requesters, results tagged with requester id.
// Latency: accept in cycle N gives rsp_valid in cycle N+2; one result per cycle when unstalled.
// Backpressure: rsp_ready low freezes the product stage, the operand stage fills once, then req_ready drops.

// Combinational GF(2^32) multiply modulo x^32 + x^7 + x^3 + x^2 + 1.
// Latency: none (pure combinational).
// Backpressure: not applicable.
module field_mult_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] p
);
    localparam logic [32:0] POLY = 33'h1_0000_008D;

    logic [62:0] cl;

    // Carry-less product, then fold the high bits back down with the field polynomial.
    always_comb begin
        cl = '0;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) cl = cl ^ ({31'b0, a} << i);
        end
        for (int i = 62; i >= 32; i--) begin
            if (cl[i]) cl = cl ^ ({30'b0, POLY} << (i - 32));
        end
        p = cl[31:0];
    end
endmodule

module field_mult_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_data,
    output logic                 busy
);
    logic [31:0]    a_q, a_d, b_q, b_d;
    logic [IDW-1:0] id1_q, id1_d;
    logic           v1_q, v1_d;
    logic [31:0]    prod_q, prod_d;
    logic [IDW-1:0] id2_q, id2_d;
    logic           v2_q, v2_d;
    logic [IDW-1:0] ptr_q, ptr_d;

    logic           adv1, adv2, any_vld, accept;
    logic [IDW-1:0] gnt_id;
    logic [31:0]    a_sel, b_sel, mult_p;

    field_mult_32 u_mult (
        .a (a_q),
        .b (b_q),
        .p (mult_p)
    );

    assign adv2    = !v2_q || rsp_ready;
    assign adv1    = !v1_q || adv2;
    assign any_vld = |req_valid;
    // Holding off grants during reset keeps a requester from believing a discarded pair was taken.
    assign accept  = adv1 && any_vld && !rst;

    // Round-robin pick: scan downward in offset so the nearest valid index at or after ptr wins.
    always_comb begin
        gnt_id = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(ptr_q) + k) % NREQ]) gnt_id = IDW'((int'(ptr_q) + k) % NREQ);
        end
    end

    // One-hot ready for the granted requester and mux of its operands.
    always_comb begin
        req_ready = '0;
        a_sel     = '0;
        b_sel     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_id == IDW'(i)) begin
                req_ready[i] = accept;
                a_sel        = req_a[32*i +: 32];
                b_sel        = req_b[32*i +: 32];
            end
        end
    end

    // Pipeline next-state: stalled stages hold, advancing stages shift as a unit.
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        id1_d  = id1_q;
        v1_d   = v1_q;
        prod_d = prod_q;
        id2_d  = id2_q;
        v2_d   = v2_q;
        ptr_d  = ptr_q;
        if (adv1) begin
            if (accept) begin
                a_d   = a_sel;
                b_d   = b_sel;
                id1_d = gnt_id;
                v1_d  = 1'b1;
                ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
            end else begin
                v1_d  = 1'b0;
            end
        end
        if (adv2) begin
            v2_d   = v1_q;
            prod_d = mult_p;
            id2_d  = id1_q;
        end
    end

    // State registers with synchronous reset discarding everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            id1_q  <= '0;
            v1_q   <= 1'b0;
            prod_q <= '0;
            id2_q  <= '0;
            v2_q   <= 1'b0;
            ptr_q  <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            id1_q  <= id1_d;
            v1_q   <= v1_d;
            prod_q <= prod_d;
            id2_q  <= id2_d;
            v2_q   <= v2_d;
            ptr_q  <= ptr_d;
        end
    end

    assign rsp_valid = v2_q;
    assign rsp_id    = id2_q;
    assign rsp_data  = prod_q;
    assign busy      = v1_q || v2_q;
endmodule

// File: tb/tb_field_mult_arbiter.sv
// Bench for field_mult_arbiter: directed scenarios with literal expectations plus a per-cycle reference model.
// Latency: model expects each response two cycles after its accept, in accept order, held until taken.
// Backpressure: model allows an accept while fewer than two entries are in flight or the head is being taken.
module tb_field_mult_arbiter;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [127:0] req_a = '0;
    logic [127:0] req_b = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_data;
    logic         busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] d;
        int          acc;
    } ent_t;

    ent_t       mq[$];
    logic [1:0] mptr = '0;
    logic [3:0] acc_mask = '0;
    int         cyc = 0;
    bit         chk_en = 1'b0;

    field_mult_arbiter #(.NREQ(4), .IDW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Field multiply by shift-and-reduce: a*x^i accumulated for each set bit of b.
    function automatic logic [31:0] gf_mul(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r, x;
        logic        c;
        r = '0;
        x = a;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) r = r ^ x;
            c = x[31];
            x = x << 1;
            if (c) x = x ^ 32'h0000_008D;
        end
        return r;
    endfunction

    // Reference model and comparison, once per cycle away from the active edge.
    always @(negedge clk) begin
        int   g;
        bit   any, can, exp_v;
        logic [3:0] exp_rdy;
        ent_t e;
        cyc++;
        acc_mask = '0;
        if (rst) begin
            if (chk_en) chk("ready_in_reset", {28'b0, req_ready}, 32'h0);
            mq.delete();
            mptr = '0;
        end else if (chk_en) begin
            any = |req_valid;
            g = 0;
            for (int k = 0; k < 4; k++) begin
                if (req_valid[(int'(mptr) + k) % 4]) begin
                    g = (int'(mptr) + k) % 4;
                    break;
                end
            end
            can = (mq.size() < 2) || rsp_ready;
            exp_rdy = (any && can) ? (4'b0001 << g) : 4'b0000;
            exp_v = (mq.size() > 0) && (cyc >= mq[0].acc + 2);
            chk("req_ready", {28'b0, req_ready}, {28'b0, exp_rdy});
            chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_v});
            chk("busy", {31'b0, busy}, {31'b0, mq.size() > 0});
            if (exp_v) begin
                chk("rsp_id", {30'b0, rsp_id}, {30'b0, mq[0].id});
                chk("rsp_data", rsp_data, mq[0].d);
                if (rsp_ready) void'(mq.pop_front());
            end
            if (any && can) begin
                e.id  = 2'(g);
                e.d   = gf_mul(req_a[32*g +: 32], req_b[32*g +: 32]);
                e.acc = cyc;
                mq.push_back(e);
                mptr = 2'((g + 1) % 4);
                acc_mask = exp_rdy;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        req_valid = '0;
        rsp_ready = 1'b1;
        while (mq.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        chk("drain", mq.size(), 0);
        tick();
    endtask

    // Single-shot request from one requester, then drain.
    task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b);
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
        req_valid = 4'b0001 << id;
        tick();
        req_valid = '0;
        drain();
    endtask

    logic [3:0] pat4;
    int         exp4[6];

    initial begin
        pat4 = 4'b0;
        exp4 = '{0, 1, 0, 1, 0, 1};

        // Reset state
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        #1;
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_req_ready", {28'b0, req_ready}, 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_rsp_id", {30'b0, rsp_id}, 32'h0);

        // 1: single request from requester 2
        rst = 1'b0;
        rsp_ready = 1'b1;
        req_a[64 +: 32] = 32'h1234_5678;
        req_b[64 +: 32] = 32'h0000_0001;
        req_valid = 4'b0100;
        #1;
        chk("t1_ready", {28'b0, req_ready}, 32'h4);
        tick();
        req_valid = '0;
        #1;
        chk("t1_not_yet", {31'b0, rsp_valid}, 32'h0);
        tick();
        #1;
        chk("t1_valid", {31'b0, rsp_valid}, 32'h1);
        chk("t1_data", rsp_data, 32'h1234_5678);
        chk("t1_id", {30'b0, rsp_id}, 32'h2);
        tick();
        // ptr must now point at 3: peek without letting an edge accept
        req_valid = 4'b1111;
        #1;
        chk("t1_ptr3", {28'b0, req_ready}, 32'h8);

        // 5: zero operand from requester 3 (returns ptr to 0)
        req_valid = 4'b1000;
        req_a[96 +: 32] = 32'hFFFF_FFFF;
        req_b[96 +: 32] = 32'h0000_0000;
        tick();
        req_valid = '0;
        tick();
        #1;
        chk("t5_valid", {31'b0, rsp_valid}, 32'h1);
        chk("t5_data", rsp_data, 32'h0);
        chk("t5_id", {30'b0, rsp_id}, 32'h3);
        tick();

        // Reduction pin: x^31 * x = x^7 + x^3 + x^2 + 1
        req_valid = 4'b0001;
        req_a[0 +: 32] = 32'h8000_0000;
        req_b[0 +: 32] = 32'h0000_0002;
        tick();
        req_valid = '0;
        tick();
        #1;
        chk("red_data", rsp_data, 32'h0000_008D);
        tick();
        issue(3, 32'h0000_000A, 32'h0000_0003);

        // 2: all four valid from ptr=0, back-to-back
        for (int i = 0; i < 4; i++) begin
            req_a[32*i +: 32] = 32'h2;
            req_b[32*i +: 32] = 32'h2;
        end
        req_valid = 4'b1111;
        for (int t = 0; t < 6; t++) begin
            if (t == 4) req_valid = '0;
            #1;
            if (t < 4) chk("t2_grant", {28'b0, req_ready}, 32'h1 << t);
            if (t >= 2) begin
                chk("t2_valid", {31'b0, rsp_valid}, 32'h1);
                chk("t2_id", {30'b0, rsp_id}, t - 2);
                chk("t2_data", rsp_data, 32'h4);
            end
            tick();
        end
        drain();

        // 3: backpressure with requesters 1 and 3 streaming
        req_a[32 +: 32] = 32'h3; req_b[32 +: 32] = 32'h5;
        req_a[96 +: 32] = 32'h7; req_b[96 +: 32] = 32'h3;
        rsp_ready = 1'b0;
        req_valid = 4'b1010;
        for (int t = 0; t < 6; t++) begin
            #1;
            chk("t3_ready", {28'b0, req_ready}, (t == 0) ? 32'h2 : (t == 1) ? 32'h8 : 32'h0);
            if (t >= 2) begin
                chk("t3_hold_valid", {31'b0, rsp_valid}, 32'h1);
                chk("t3_hold_id", {30'b0, rsp_id}, 32'h1);
                chk("t3_hold_data", rsp_data, 32'hF);
            end
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        #1;
        chk("t3_first_id", {30'b0, rsp_id}, 32'h1);
        chk("t3_first_data", rsp_data, 32'hF);
        tick();
        #1;
        chk("t3_second_valid", {31'b0, rsp_valid}, 32'h1);
        chk("t3_second_id", {30'b0, rsp_id}, 32'h3);
        chk("t3_second_data", rsp_data, 32'h9);
        tick();
        #1;
        chk("t3_empty", {31'b0, rsp_valid}, 32'h0);
        drain();

        // 4: fairness, req 0 always valid, req 1 pulsing
        req_a[0 +: 32] = 32'h1; req_b[0 +: 32] = 32'h1;
        req_a[32 +: 32] = 32'h1; req_b[32 +: 32] = 32'h1;
        for (int t = 0; t < 6; t++) begin
            pat4 = {2'b00, (t == 1 || t >= 3) ? 1'b1 : 1'b0, 1'b1};
            req_valid = pat4;
            #1;
            chk("t4_grant", {28'b0, req_ready}, 32'h1 << exp4[t]);
            tick();
        end
        drain();

        // 6: reset with both stages full
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        tick();
        tick();
        #1;
        chk("t6_full_busy", {31'b0, busy}, 32'h1);
        chk("t6_full_valid", {31'b0, rsp_valid}, 32'h1);
        chk("t6_full_ready", {28'b0, req_ready}, 32'h0);
        rst = 1'b1;
        req_valid = '0;
        tick();
        rst = 1'b0;
        #1;
        chk("t6_valid", {31'b0, rsp_valid}, 32'h0);
        chk("t6_busy", {31'b0, busy}, 32'h0);
        chk("t6_ready", {28'b0, req_ready}, 32'h0);
        req_valid = 4'b0101;
        rsp_ready = 1'b1;
        #1;
        chk("t6_ptr0", {28'b0, req_ready}, 32'h1);
        tick();
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        drain();

        // Random traffic with operands held stable until accepted
        for (int t = 0; t < 300; t++) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_mask[i] || !req_valid[i]) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    req_a[32*i +: 32] = $urandom;
                    req_b[32*i +: 32] = $urandom;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
